// File: rtl/picorv32_regdbg.sv
// ============================================================================
// Module   : picorv32_regdbg
// Purpose  : Debug-host initiator for the PicoRV32 register-file port
//            (read / write / optional dump of x1..x31 via req/gnt arbitration).
//            Dump support is built only when PICORV32_REGDBG_DUMP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module picorv32_regdbg (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_addr,
    output logic        rsp_err,
    output logic        rsp_last,
    output logic        rf_req,
    input  logic        rf_gnt,
    output logic        rf_wen,
    output logic [5:0]  rf_waddr,
    output logic [5:0]  rf_raddr,
    output logic [31:0] rf_wdata,
    input  logic [31:0] rf_rdata
);

    localparam logic [1:0] c_OP_READ  = 2'b00;
    localparam logic [1:0] c_OP_WRITE = 2'b01;
    localparam logic [1:0] c_OP_DUMP  = 2'b10;
    localparam logic [4:0] c_LAST_REG = 5'd31;

`ifdef PICORV32_REGDBG_DUMP_EN
    localparam logic c_DUMP_EN = 1'b1;
`else
    localparam logic c_DUMP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_op;
    logic [4:0]  r_addr;
    logic [31:0] r_wdata;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic [4:0]  r_rsp_addr;
    logic        r_rsp_err;
    logic        r_rsp_last;
    logic        r_rf_req;

    logic w_cmd_dump;
    logic w_cmd_err;
    logic w_op_dump;

    assign w_cmd_dump = c_DUMP_EN && (cmd_op == c_OP_DUMP);
    assign w_cmd_err  = (cmd_op[1] == 1'b1) && !w_cmd_dump;
    assign w_op_dump  = c_DUMP_EN && (r_op == c_OP_DUMP);

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_addr  = r_rsp_addr;
    assign rsp_err   = r_rsp_err;
    assign rsp_last  = r_rsp_last;
    assign rf_req    = r_rf_req;
    assign rf_waddr  = {1'b0, r_addr};
    assign rf_raddr  = {1'b0, r_addr};
    assign rf_wdata  = r_wdata;

    // Gated by rst so a reset arriving in the grant cycle cannot commit a write.
    assign rf_wen = (r_state == ST_ACQ) && rf_gnt && (r_op == c_OP_WRITE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= c_OP_READ;
            r_addr      <= 5'd0;
            r_wdata     <= 32'd0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'd0;
            r_rsp_addr  <= 5'd0;
            r_rsp_err   <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rf_req    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_op        <= cmd_op;
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wdata;
                        if (w_cmd_err) begin
                            r_state     <= ST_RSP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= 32'd0;
                            r_rsp_addr  <= cmd_addr;
                            r_rsp_last  <= 1'b1;
                        end else if (w_cmd_dump) begin
                            r_addr   <= 5'd1;
                            r_rf_req <= 1'b1;
                            r_state  <= ST_ACQ;
                        end else if (cmd_addr == 5'd0) begin
                            // x0 is never put on the port: reads yield 0, writes vanish.
                            r_state     <= ST_RSP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b0;
                            r_rsp_data  <= (cmd_op == c_OP_WRITE) ? cmd_wdata : 32'd0;
                            r_rsp_addr  <= 5'd0;
                            r_rsp_last  <= 1'b1;
                        end else begin
                            r_rf_req <= 1'b1;
                            r_state  <= ST_ACQ;
                        end
                    end
                end
                ST_ACQ: begin
                    if (rf_gnt) begin
                        r_rsp_data  <= (r_op == c_OP_WRITE) ? r_wdata : rf_rdata;
                        r_rsp_addr  <= r_addr;
                        r_rsp_err   <= 1'b0;
                        r_rsp_last  <= !w_op_dump || (r_addr == c_LAST_REG);
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (w_op_dump && (r_addr != c_LAST_REG)) begin
                            r_addr  <= r_addr + 5'd1;
                            r_state <= ST_ACQ;
                        end else begin
                            r_rf_req    <= 1'b0;
                            r_cmd_ready <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_picorv32_regdbg.sv
// ============================================================================
// Module   : tb_picorv32_regdbg
// Purpose  : Scoreboard bench for picorv32_regdbg with a register-file model;
//            dump expectations follow PICORV32_REGDBG_DUMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_picorv32_regdbg;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        err;
        logic        last;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [4:0]  cmd_addr = 5'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_addr;
    logic        rsp_err;
    logic        rsp_last;
    logic        rf_req;
    logic        rf_gnt = 1'b1;
    logic        rf_wen;
    logic [5:0]  rf_waddr;
    logic [5:0]  rf_raddr;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata;

    logic [31:0] rf_mem [32];
    logic [31:0] exp_rf [32];
    rsp_t        sb [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int wen_cnt = 0;
    bit req_seen = 1'b0;
    logic stall = 1'b0;
    rsp_t held;

    always #5 clk = ~clk;

    picorv32_regdbg dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_addr(rsp_addr), .rsp_err(rsp_err), .rsp_last(rsp_last),
        .rf_req(rf_req), .rf_gnt(rf_gnt), .rf_wen(rf_wen),
        .rf_waddr(rf_waddr), .rf_raddr(rf_raddr), .rf_wdata(rf_wdata),
        .rf_rdata(rf_rdata)
    );

    assign rf_rdata = rf_mem[rf_raddr[4:0]];

    // Register-file model plus port-protocol and response-stability monitors.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rf_req) req_seen = 1'b1;
        if (rf_wen) begin
            rf_mem[rf_waddr[4:0]] <= rf_wdata;
            wen_cnt++;
            checks++;
            if (!rf_gnt || !rf_req || rf_waddr[5] || rf_waddr[4:0] == 5'd0) begin
                errors++;
                $display("FAIL rf_wen_protocol: gnt=%b req=%b waddr=%h", rf_gnt, rf_req, rf_waddr);
            end
        end
        stall <= rsp_valid && !rsp_ready && !rst;
        held  <= {rsp_data, rsp_addr, rsp_err, rsp_last};
    end

    always @(negedge clk) begin
        if (stall) begin
            checks++;
            if (rsp_valid !== 1'b1 || {rsp_data, rsp_addr, rsp_err, rsp_last} !== held) begin
                errors++;
                $display("FAIL rsp_stable: valid=%b got=%h required=%h", rsp_valid,
                         {rsp_data, rsp_addr, rsp_err, rsp_last}, held);
            end
        end
    end

    task automatic send_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] wd);
        int w = 0;
        while (cmd_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_timeout: cmd_ready=%b required 1", cmd_ready);
            return;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
        hs_cyc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string nm, input int exp_lat, input bit rand_ready);
        int   w = 0;
        rsp_t exp_r;
        rsp_t got;
        while (rsp_valid !== 1'b1 && w < 200) begin @(negedge clk); w++; end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: rsp_valid=%b required 1", nm, rsp_valid);
            return;
        end
        if (exp_lat >= 0) begin
            checks++;
            if (cyc - hs_cyc != exp_lat) begin
                errors++;
                $display("FAIL %s_latency: got %0d required %0d", nm, cyc - hs_cyc, exp_lat);
            end
        end
        got = {rsp_data, rsp_addr, rsp_err, rsp_last};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected: got data=%h addr=%0d, required no response", nm, rsp_data, rsp_addr);
        end else begin
            exp_r = sb.pop_front();
            if (got !== exp_r) begin
                errors++;
                $display("FAIL %s: got data=%h addr=%0d err=%b last=%b required data=%h addr=%0d err=%b last=%b",
                         nm, got.data, got.addr, got.err, got.last,
                         exp_r.data, exp_r.addr, exp_r.err, exp_r.last);
            end
        end
        if (rand_ready) repeat ($urandom_range(0, 2)) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, rf_req, rf_wen, rsp_err, rsp_last} !== 6'b0 ||
            rsp_data !== 32'd0 || rsp_addr !== 5'd0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b val=%b req=%b wen=%b err=%b last=%b data=%h addr=%0d required all 0",
                     cmd_ready, rsp_valid, rf_req, rf_wen, rsp_err, rsp_last, rsp_data, rsp_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        int w0 = wen_cnt;
        rf_gnt = 1'b1;
        exp_rf[5] = 32'hDEADBEEF;
        sb.push_back({32'hDEADBEEF, 5'd5, 1'b0, 1'b1});
        send_cmd(2'b01, 5'd5, 32'hDEADBEEF);
        get_rsp("write_x5", 2, 1'b0);
        checks++;
        if (wen_cnt - w0 != 1 || rf_mem[5] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_x5_port: wen pulses %0d mem=%h required 1 pulse mem=deadbeef",
                     wen_cnt - w0, rf_mem[5]);
        end
    endtask

    task automatic test_read();
        sb.push_back({exp_rf[5], 5'd5, 1'b0, 1'b1});
        send_cmd(2'b00, 5'd5, 32'h0);
        get_rsp("read_x5", 2, 1'b0);
        sb.push_back({exp_rf[17], 5'd17, 1'b0, 1'b1});
        send_cmd(2'b00, 5'd17, 32'h0);
        get_rsp("read_x17", 2, 1'b0);
    endtask

    task automatic test_x0_and_err();
        int w0 = wen_cnt;
        req_seen = 1'b0;
        sb.push_back({32'd0, 5'd0, 1'b0, 1'b1});
        send_cmd(2'b00, 5'd0, 32'h0);
        get_rsp("read_x0", 1, 1'b0);
        sb.push_back({32'h1234, 5'd0, 1'b0, 1'b1});
        send_cmd(2'b01, 5'd0, 32'h1234);
        get_rsp("write_x0", 1, 1'b0);
        checks++;
        if (req_seen || wen_cnt != w0) begin
            errors++;
            $display("FAIL x0_no_port: req_seen=%b wen pulses=%0d required 0/0", req_seen, wen_cnt - w0);
        end
        sb.push_back({32'd0, 5'd9, 1'b1, 1'b1});
        send_cmd(2'b11, 5'd9, 32'hFFFF_FFFF);
        get_rsp("reserved_op", 1, 1'b0);
        checks++;
        if (req_seen) begin
            errors++;
            $display("FAIL reserved_no_req: rf_req seen=%b required 0", req_seen);
        end
    endtask

    task automatic test_gnt_stall();
        rf_gnt = 1'b0;
        exp_rf[12] = 32'hA5A5_0F0F;
        sb.push_back({32'hA5A5_0F0F, 5'd12, 1'b0, 1'b1});
        send_cmd(2'b01, 5'd12, 32'hA5A5_0F0F);
        sb.push_back({exp_rf[12], 5'd12, 1'b0, 1'b1});
        get_rsp_after_stall("write_gnt_low");
        send_cmd(2'b00, 5'd12, 32'h0);
        get_rsp_after_stall("read_gnt_low");
    endtask

    task automatic get_rsp_after_stall(input string nm);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rf_req !== 1'b1 || rf_wen !== 1'b0 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_wait: req=%b wen=%b valid=%b required 1/0/0", nm, rf_req, rf_wen, rsp_valid);
            end
            @(negedge clk);
            rf_gnt = (i == 3);
        end
        get_rsp(nm, 6, 1'b0);
        rf_gnt = 1'b0;
    endtask

    task automatic test_dump();
`ifdef PICORV32_REGDBG_DUMP_EN
        bit done = 1'b0;
        rf_gnt = 1'b1;
        for (int i = 1; i < 32; i++) sb.push_back({exp_rf[i], i[4:0], 1'b0, i == 31});
        send_cmd(2'b10, 5'd0, 32'h0);
        for (int k = 1; k < 32; k++) get_rsp("dump_fast", 2 * k, 1'b0);
        for (int i = 1; i < 32; i++) sb.push_back({exp_rf[i], i[4:0], 1'b0, i == 31});
        send_cmd(2'b10, 5'd3, 32'h0);
        fork
            begin
                for (int k = 1; k < 32; k++) get_rsp("dump_rand", -1, 1'b1);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    rf_gnt = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rf_gnt = 1'b1;
`else
        sb.push_back({32'd0, 5'd7, 1'b1, 1'b1});
        send_cmd(2'b10, 5'd7, 32'h0);
        get_rsp("dump_disabled", 1, 1'b0);
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL dump_leftover: %0d responses missing, required 0", sb.size());
        end
    endtask

    task automatic test_rst_mid();
        int w0;
        logic [31:0] keep;
        rf_gnt = 1'b0;
        keep = rf_mem[9];
        send_cmd(2'b01, 5'd9, 32'h5555_AAAA);
        w0 = wen_cnt;
        rst = 1'b1; rf_gnt = 1'b1;
        @(negedge clk);
        checks++;
        if (rf_req !== 1'b0 || rsp_valid !== 1'b0 || wen_cnt != w0 || rf_mem[9] !== keep) begin
            errors++;
            $display("FAIL rst_in_acq: req=%b valid=%b wen pulses=%0d mem=%h required 0/0/0/%h",
                     rf_req, rsp_valid, wen_cnt - w0, rf_mem[9], keep);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_acq_ready: got %b required 1", cmd_ready);
        end
        send_cmd(2'b00, 5'd3, 32'h0);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_rsp_setup: rsp_valid=%b required 0 in access cycle", rsp_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (rf_req !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_rsp: req=%b valid=%b required 0/0", rf_req, rsp_valid);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_rsp_ready: ready=%b valid=%b required 1/0", cmd_ready, rsp_valid);
        end
        sb.push_back({exp_rf[3], 5'd3, 1'b0, 1'b1});
        send_cmd(2'b00, 5'd3, 32'h0);
        get_rsp("read_after_rst", 2, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            logic [31:0] v;
            v = $urandom;
            rf_mem[i] = v;
            exp_rf[i] = v;
        end
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_x0_and_err();
        test_gnt_stall();
        test_dump();
        test_rst_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
